// File: rtl/bypass_net_if.sv
// bypass_net_if: decode/pipeline bus for the operand bypass network.
//   master: pipeline side (drives decode sources, stage destinations/values,
//           E_stall; observes resolved operands, stall/bubble, E register,
//           performance counters)
//   slave : bypass_net side
interface bypass_net_if #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NSRC = 2,
  parameter int CW   = 32
);
  logic                 d_valid;
  logic [NSRC*AW-1:0]   d_srcs;
  logic [NSRC*DW-1:0]   d_rvals;
  logic [AW-1:0]        E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [DW-1:0]        e_valE, M_valE, m_valM, W_valE, W_valM;
  logic                 E_stall;

  logic [NSRC*DW-1:0]   d_vals;
  logic                 d_stall;
  logic                 e_bubble;
  logic [NSRC*DW-1:0]   E_vals;
  logic [NSRC*AW-1:0]   E_srcs;
  logic                 E_valid;
  logic [CW-1:0]        lu_cnt;
  logic [CW-1:0]        fwd_cnt;

  modport master (
    output d_valid, d_srcs, d_rvals, E_dstE, E_dstM, M_dstE, M_dstM,
           W_dstE, W_dstM, e_valE, M_valE, m_valM, W_valE, W_valM, E_stall,
    input  d_vals, d_stall, e_bubble, E_vals, E_srcs, E_valid, lu_cnt, fwd_cnt
  );

  modport slave (
    input  d_valid, d_srcs, d_rvals, E_dstE, E_dstM, M_dstE, M_dstM,
           W_dstE, W_dstM, e_valE, M_valE, m_valM, W_valE, W_valM, E_stall,
    output d_vals, d_stall, e_bubble, E_vals, E_srcs, E_valid, lu_cnt, fwd_cnt
  );
endinterface

// File: rtl/bypass_net.sv
// bypass_net: operand bypass network with load-use interlock and D/E operand
// register for the pipelined MIPS core.
//   clk, rst : clock, synchronous active-high reset
//   bus      : bypass_net_if.slave (decode sources, E/M/W destinations and
//              values, E_stall in; resolved operands, d_stall, e_bubble,
//              E register, lu_cnt/fwd_cnt out)
// Optional feature: define BYPASS_PERF_EN to build the saturating lu_cnt /
// fwd_cnt counters; otherwise both are tied to zero.

// Per-slot resolver: youngest in-flight producer wins, RNONE never matches.
module bypass_slot #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int RNONE = 0
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] rval,
  input  logic [AW-1:0] eDstE, eDstM, mDstM, mDstE, wDstM, wDstE,
  input  logic [DW-1:0] eValE, mValM, mValE, wValM, wValE,
  output logic [DW-1:0] val,
  output logic          fwd,
  output logic          lu
);
  localparam logic [AW-1:0] RN = AW'(RNONE);

  function automatic logic hit(input logic [AW-1:0] s, input logic [AW-1:0] d);
    return (s != RN) && (s == d);
  endfunction

  always_comb begin
    val = rval;
    fwd = 1'b1;
    if      (hit(src, eDstE)) val = eValE;
    else if (hit(src, mDstM)) val = mValM;
    else if (hit(src, mDstE)) val = mValE;
    else if (hit(src, wDstM)) val = wValM;
    else if (hit(src, wDstE)) val = wValE;
    else                      fwd = 1'b0;
  end

  // An ALU result already in E shadows the same register being loaded.
  assign lu = hit(src, eDstM) & ~hit(src, eDstE);
endmodule

module bypass_net #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int RNONE = 0,
  parameter int CW    = 32
) (
  input  logic       clk,
  input  logic       rst,
  bypass_net_if.slave bus
);
  localparam logic [AW-1:0] RN = AW'(RNONE);

  logic [NSRC*DW-1:0] dVals;
  logic [NSRC-1:0]    fwdVec, luVec;
  logic               loadUse;

  for (genvar i = 0; i < NSRC; i++) begin : gSlot
    bypass_slot #(.DW(DW), .AW(AW), .RNONE(RNONE)) uSlot (
      .src  (bus.d_srcs[i*AW +: AW]),
      .rval (bus.d_rvals[i*DW +: DW]),
      .eDstE(bus.E_dstE), .eDstM(bus.E_dstM),
      .mDstM(bus.M_dstM), .mDstE(bus.M_dstE),
      .wDstM(bus.W_dstM), .wDstE(bus.W_dstE),
      .eValE(bus.e_valE), .mValM(bus.m_valM), .mValE(bus.M_valE),
      .wValM(bus.W_valM), .wValE(bus.W_valE),
      .val  (dVals[i*DW +: DW]),
      .fwd  (fwdVec[i]),
      .lu   (luVec[i])
    );
  end

  assign loadUse      = bus.d_valid & (|luVec);
  assign bus.d_vals   = dVals;
  assign bus.d_stall  = loadUse | bus.E_stall;
  assign bus.e_bubble = loadUse & ~bus.E_stall;

  logic [NSRC*DW-1:0] eVals;
  logic [NSRC*AW-1:0] eSrcs;
  logic               eValid;

  always_ff @(posedge clk) begin
    if (rst) begin
      eVals  <= '0;
      eSrcs  <= {NSRC{RN}};
      eValid <= 1'b0;
    end else if (bus.E_stall) begin
      eVals  <= eVals;
      eSrcs  <= eSrcs;
      eValid <= eValid;
    end else if (bus.e_bubble) begin
      eVals  <= '0;
      eSrcs  <= {NSRC{RN}};
      eValid <= 1'b0;
    end else begin
      eVals  <= dVals;
      eSrcs  <= bus.d_srcs;
      eValid <= bus.d_valid;
    end
  end

  assign bus.E_vals  = eVals;
  assign bus.E_srcs  = eSrcs;
  assign bus.E_valid = eValid;

`ifdef BYPASS_PERF_EN
  logic [CW-1:0] luCnt, fwdCnt;
  logic [CW:0]   fwdSum;
  logic          eLoad;

  // One extra bit catches overflow; at most NSRC is added per edge.
  always_comb begin
    fwdSum = {1'b0, fwdCnt};
    for (int i = 0; i < NSRC; i++) fwdSum = fwdSum + (CW+1)'(fwdVec[i]);
  end

  assign eLoad = ~bus.E_stall & ~bus.e_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      luCnt  <= '0;
      fwdCnt <= '0;
    end else begin
      if (bus.e_bubble && luCnt != '1) luCnt <= luCnt + CW'(1);
      if (eLoad && bus.d_valid) fwdCnt <= fwdSum[CW] ? '1 : fwdSum[CW-1:0];
    end
  end

  assign bus.lu_cnt  = luCnt;
  assign bus.fwd_cnt = fwdCnt;
`else
  logic unusedFwd;
  assign unusedFwd   = ^fwdVec;
  assign bus.lu_cnt  = '0;
  assign bus.fwd_cnt = '0;
`endif
endmodule

// File: tb/tb_bypass_net.sv
module tb_bypass_net;
  localparam int DW = 32, AW = 5, NSRC = 2, RNONE = 0;
`ifdef BYPASS_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  bypass_net_if #(.DW(DW), .AW(AW), .NSRC(NSRC), .CW(CW)) bus ();
  bypass_net #(.DW(DW), .AW(AW), .NSRC(NSRC), .RNONE(RNONE), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic logic [DW-1:0] resolve(input int i, output bit fwd);
    logic [AW-1:0] s;
    logic [AW-1:0] dst[5];
    logic [DW-1:0] val[5];
    logic [DW-1:0] r;
    s   = bus.d_srcs[i*AW +: AW];
    dst = '{bus.E_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    val = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    r   = bus.d_rvals[i*DW +: DW];
    fwd = 0;
    if (s != AW'(RNONE))
      for (int k = 0; k < 5; k++)
        if (dst[k] == s) begin r = val[k]; fwd = 1; break; end
    return r;
  endfunction

  function automatic bit slotLu(input int i);
    logic [AW-1:0] s;
    s = bus.d_srcs[i*AW +: AW];
    return s != AW'(RNONE) && s == bus.E_dstM && s != bus.E_dstE;
  endfunction

  logic [DW-1:0] mVals[NSRC];
  logic [AW-1:0] mSrcs[NSRC];
  bit     mValid, mKnown = 0;
  longint mLu, mFwd;

  always @(negedge clk) begin
    bit anyLu, bubble;
    bit lu[NSRC];
    bit fw[NSRC];
    logic [DW-1:0] r[NSRC];
    int nf;
    anyLu = 0; nf = 0;
    for (int i = 0; i < NSRC; i++) begin
      r[i]  = resolve(i, fw[i]);
      lu[i] = slotLu(i);
      anyLu |= lu[i];
      nf += fw[i];
    end
    anyLu  = anyLu & bus.d_valid;
    bubble = anyLu & !bus.E_stall;
    chk("d_stall", 64'(bus.d_stall), 64'(anyLu | bus.E_stall));
    chk("e_bubble", 64'(bus.e_bubble), 64'(bubble));
    for (int i = 0; i < NSRC; i++)
      if (!(anyLu && lu[i])) chk($sformatf("d_vals[%0d]", i), 64'(bus.d_vals[i*DW +: DW]), 64'(r[i]));
    if (mKnown) begin
      for (int i = 0; i < NSRC; i++) begin
        chk($sformatf("E_vals[%0d]", i), 64'(bus.E_vals[i*DW +: DW]), 64'(mVals[i]));
        chk($sformatf("E_srcs[%0d]", i), 64'(bus.E_srcs[i*AW +: AW]), 64'(mSrcs[i]));
      end
      chk("E_valid", 64'(bus.E_valid), 64'(mValid));
      chk("lu_cnt", 64'(bus.lu_cnt), 64'(mLu));
      chk("fwd_cnt", 64'(bus.fwd_cnt), 64'(mFwd));
    end
    // state the model expects after the coming edge
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin mVals[i] = '0; mSrcs[i] = AW'(RNONE); end
      mValid = 0; mLu = 0; mFwd = 0; mKnown = 1;
    end else if (bus.E_stall) begin
      // frozen
    end else if (bubble) begin
      for (int i = 0; i < NSRC; i++) begin mVals[i] = '0; mSrcs[i] = AW'(RNONE); end
      mValid = 0;
`ifdef BYPASS_PERF_EN
      if (mLu < CMAX) mLu++;
`endif
    end else begin
      for (int i = 0; i < NSRC; i++) begin mVals[i] = r[i]; mSrcs[i] = bus.d_srcs[i*AW +: AW]; end
      mValid = bus.d_valid;
`ifdef BYPASS_PERF_EN
      if (bus.d_valid) mFwd = (mFwd + nf > CMAX) ? CMAX : mFwd + nf;
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic clearIns();
    bus.d_valid = 0; bus.d_srcs = '0; bus.E_stall = 0;
    bus.d_rvals = {$urandom, $urandom};
    bus.E_dstE = 0; bus.E_dstM = 0; bus.M_dstE = 0; bus.M_dstM = 0; bus.W_dstE = 0; bus.W_dstM = 0;
    bus.e_valE = $urandom; bus.M_valE = $urandom; bus.m_valM = $urandom;
    bus.W_valE = $urandom; bus.W_valM = $urandom;
  endtask

  function automatic logic [AW-1:0] rid();
    return AW'($urandom_range(0, 3));
  endfunction

  task automatic randIns();
    bus.d_valid = ($urandom_range(0, 9) != 0);
    bus.d_srcs  = {rid(), rid()};
    bus.d_rvals = {$urandom, $urandom};
    bus.E_dstE = rid(); bus.E_dstM = rid(); bus.M_dstE = rid();
    bus.M_dstM = rid(); bus.W_dstE = rid(); bus.W_dstM = rid();
    bus.e_valE = $urandom; bus.M_valE = $urandom; bus.m_valM = $urandom;
    bus.W_valE = $urandom; bus.W_valM = $urandom;
    bus.E_stall = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    logic [DW-1:0] expLu;
    rst = 1; randIns();
    tick(); randIns(); tick();
    chk("reset E_valid", 64'(bus.E_valid), 64'(0));
    chk("reset E_vals", 64'(bus.E_vals), 64'(0));
    chk("reset E_srcs", 64'(bus.E_srcs), 64'(0));
    chk("reset lu_cnt", 64'(bus.lu_cnt), 64'(0));
    rst = 0;

    // priority: E_dstE > M_dstM > W_dstE
    clearIns(); bus.d_valid = 1; bus.d_srcs = {5'd8, 5'd8};
    bus.E_dstE = 8; bus.e_valE = 32'h11; bus.M_dstM = 8; bus.m_valM = 32'h22;
    bus.W_dstE = 8; bus.W_valE = 32'h33;
    #1 chk("prio E slot0", 64'(bus.d_vals[31:0]), 64'h11);
       chk("prio E slot1", 64'(bus.d_vals[63:32]), 64'h11);
    bus.E_dstE = 0;
    #1 chk("prio M slot1", 64'(bus.d_vals[63:32]), 64'h22);
    bus.M_dstM = 0;
    #1 chk("prio W slot0", 64'(bus.d_vals[31:0]), 64'h33);
    tick();

    // $zero is never forwarded
    clearIns(); bus.d_valid = 1; bus.d_rvals[31:0] = 32'hDEAD;
    #1 chk("zero slot0", 64'(bus.d_vals[31:0]), 64'hDEAD);
       chk("zero stall", 64'(bus.d_stall), 64'(0));
    tick();

    // load-use: one bubble, then resolve from M_dstM
    clearIns(); bus.d_valid = 1; bus.d_srcs = {5'd9, 5'd3};
    bus.d_rvals = {32'h0, 32'h1234}; bus.E_dstM = 9;
    #1 chk("lu stall", 64'(bus.d_stall), 64'(1));
       chk("lu bubble", 64'(bus.e_bubble), 64'(1));
    tick();
    chk("lu E_valid", 64'(bus.E_valid), 64'(0));
`ifdef BYPASS_PERF_EN
    chk("lu_cnt one", 64'(bus.lu_cnt), 64'(1));
`else
    chk("lu_cnt tied", 64'(bus.lu_cnt), 64'(0));
`endif
    bus.E_dstM = 0; bus.M_dstM = 9; bus.m_valM = 32'h55;
    #1 chk("lu resolved stall", 64'(bus.d_stall), 64'(0));
    tick();
    chk("lu E_vals slot1", 64'(bus.E_vals[63:32]), 64'h55);
    chk("lu E_valid after", 64'(bus.E_valid), 64'(1));

    // freeze for 3 cycles, including a concurrent load-use
    expLu = bus.lu_cnt;
    for (int c = 0; c < 3; c++) begin
      bus.E_stall = 1; bus.d_srcs = {rid() + 5'd4, rid()};
      bus.E_dstM = (c == 1) ? bus.d_srcs[4:0] : 5'd0;
      if (c == 1 && bus.E_dstM == 0) bus.E_dstM = 0;
      #1 chk("frz stall", 64'(bus.d_stall), 64'(1));
         chk("frz bubble", 64'(bus.e_bubble), 64'(0));
      tick();
      chk("frz E_vals slot1", 64'(bus.E_vals[63:32]), 64'h55);
      chk("frz E_vals slot0", 64'(bus.E_vals[31:0]), 64'h1234);
      chk("frz E_srcs", 64'(bus.E_srcs), 64'({5'd9, 5'd3}));
      chk("frz lu_cnt", 64'(bus.lu_cnt), 64'(expLu));
    end

    // 20 two-slot forwarded loads
    clearIns(); bus.d_valid = 1; bus.d_srcs = {5'd6, 5'd6}; bus.W_dstE = 6;
    repeat (20) tick();
`ifdef BYPASS_PERF_EN
    chk("fwd_cnt sat", 64'(bus.fwd_cnt), 64'(15));
    tick();
    chk("fwd_cnt held", 64'(bus.fwd_cnt), 64'(15));
`else
    chk("fwd_cnt tied", 64'(bus.fwd_cnt), 64'(0));
`endif

    // randomized phase with occasional reset
    for (int n = 0; n < 3000; n++) begin
      randIns();
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0; clearIns();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
